// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// The S_BNE state and OP_BNE are only reachable when MC_BNE_EN is defined.
package mc_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTE,
      S_ALUWB,
      S_BEQ,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP,
      S_ERROR,
      S_BNE
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [1:0] ALUB_B      = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       pc_write;
      logic       branch;
      logic       illegal_op;
   } ctrl_t;

   // Terminal states hand back to FETCH and retire the instruction on that edge.
   function automatic logic is_terminal(input state_t s);
      return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) || (s == S_BEQ) ||
             (s == S_BNE) || (s == S_ADDIWB) || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller; only FETCH looks at mem_ready.
// With MC_BNE_EN defined an extra branch_ne output is produced for the S_BNE state.
module mc_output_decode
   import mc_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
`ifdef MC_BNE_EN
   output logic   branch_ne,
`endif
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
`ifdef MC_BNE_EN
      branch_ne = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = ALUB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_B;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_ALUOUT;
            ctrl.branch    = 1'b1;
         end
`ifdef MC_BNE_EN
         S_BNE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_B;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_ALUOUT;
            branch_ne      = 1'b1;
         end
`endif
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src   = PC_JUMP;
            ctrl.pc_write = 1'b1;
         end
         S_ERROR: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: state register, next-state logic and retired-instruction counter.
// Define MC_BNE_EN to add bne support and the branch_ne output.
module multicycle_controller #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_src,
   output logic                pc_write,
   output logic                branch,
   output logic                illegal_op,
`ifdef MC_BNE_EN
   output logic                branch_ne,
`endif
   output logic [CNT_W-1:0]    instr_count
);

   import mc_pkg::*;

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;
   logic   retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OPCODE_W'(OP_LW),
               OPCODE_W'(OP_SW):    state_next = S_MEMADR;
               OPCODE_W'(OP_RTYPE): state_next = S_EXECUTE;
               OPCODE_W'(OP_BEQ):   state_next = S_BEQ;
               OPCODE_W'(OP_ADDI):  state_next = S_ADDIEX;
               OPCODE_W'(OP_J):     state_next = S_JUMP;
`ifdef MC_BNE_EN
               OPCODE_W'(OP_BNE):   state_next = S_BNE;
`endif
               default:             state_next = S_ERROR;
            endcase
         end
         // The IR still holds the instruction, so lw/sw is re-examined here.
         S_MEMADR:  state_next = (opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_next = S_FETCH;
         S_EXECUTE: state_next = S_ALUWB;
         S_ADDIEX:  state_next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: state_next = S_FETCH;
`ifdef MC_BNE_EN
         S_BNE:     state_next = S_FETCH;
`endif
         S_ERROR:   state_next = S_ERROR;
         default:   state_next = S_IDLE;
      endcase
   end

   mc_output_decode u_output_decode (
      .state     (state),
      .mem_ready (mem_ready),
`ifdef MC_BNE_EN
      .branch_ne (branch_ne),
`endif
      .ctrl      (ctrl)
   );

   assign mem_req    = ctrl.mem_req;
   assign iord       = ctrl.iord;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ALUOP_W'(ctrl.alu_op);
   assign pc_src     = ctrl.pc_src;
   assign pc_write   = ctrl.pc_write;
   assign branch     = ctrl.branch;
   assign illegal_op = ctrl.illegal_op;

   // Wraps freely; ERROR is never terminal, so a trapped opcode does not count.
   assign retire = is_terminal(state) && (state_next == S_FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instr_count <= '0;
      else if (retire) instr_count <= instr_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller, plus a CNT_W=4 instance for wrap.
// Expected control words come from a per-instruction phase list with random wait states.
module tb_multicycle_controller;

   typedef struct packed {
      logic       mreq, iord, mw, irw, rd, m2r, rw, asa;
      logic [1:0] asb, aop, psrc;
      logic       pcw, br, ill, bne;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [5:0] opcode;
   logic       mem_ready;

   logic        mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_src;
   logic        pc_write, branch, illegal_op, branch_ne_obs;
   logic [31:0] instr_count;

   logic        mem_req_s, iord_s, mem_write_s, ir_write_s, reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
   logic [1:0]  alu_src_b_s, alu_op_s, pc_src_s;
   logic        pc_write_s, branch_s, illegal_op_s;
   logic [3:0]  instr_count_s;
`ifdef MC_BNE_EN
   logic        branch_ne, branch_ne_s;
   assign branch_ne_obs = branch_ne;
`else
   assign branch_ne_obs = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int unsigned cnt = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .pc_write(pc_write), .branch(branch), .illegal_op(illegal_op),
`ifdef MC_BNE_EN
      .branch_ne(branch_ne),
`endif
      .instr_count(instr_count)
   );

   multicycle_controller #(.CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req_s), .iord(iord_s), .mem_write(mem_write_s), .ir_write(ir_write_s),
      .reg_dst(reg_dst_s), .mem_to_reg(mem_to_reg_s), .reg_write(reg_write_s),
      .alu_src_a(alu_src_a_s), .alu_src_b(alu_src_b_s), .alu_op(alu_op_s), .pc_src(pc_src_s),
      .pc_write(pc_write_s), .branch(branch_s), .illegal_op(illegal_op_s),
`ifdef MC_BNE_EN
      .branch_ne(branch_ne_s),
`endif
      .instr_count(instr_count_s)
   );

   function automatic ctl_t observed();
      ctl_t c;
      c = '{mreq: mem_req, iord: iord, mw: mem_write, irw: ir_write, rd: reg_dst,
            m2r: mem_to_reg, rw: reg_write, asa: alu_src_a, asb: alu_src_b, aop: alu_op,
            psrc: pc_src, pcw: pc_write, br: branch, ill: illegal_op, bne: branch_ne_obs};
      return c;
   endfunction

   // Control word required by each instruction phase; 'go' is the memory-complete cycle.
   function automatic ctl_t phaseWord(input string ph, input bit go);
      ctl_t c = '0;
      case (ph)
         "FETCH":            begin c.mreq = 1; c.asb = 2'b01; c.irw = go; c.pcw = go; end
         "DECODE":           c.asb = 2'b11;
         "MEMADR", "ADDIEX": begin c.asa = 1; c.asb = 2'b10; end
         "MEMRD":            begin c.mreq = 1; c.iord = 1; end
         "MEMWB":            begin c.rw = 1; c.m2r = 1; end
         "MEMWR":            begin c.mreq = 1; c.iord = 1; c.mw = 1; end
         "EXECUTE":          begin c.asa = 1; c.aop = 2'b10; end
         "ALUWB":            begin c.rw = 1; c.rd = 1; end
         "BEQ":              begin c.asa = 1; c.aop = 2'b01; c.psrc = 2'b01; c.br = 1; end
         "BNE":              begin c.asa = 1; c.aop = 2'b01; c.psrc = 2'b01; c.bne = 1; end
         "ADDIWB":           c.rw = 1;
         "JUMP":             begin c.psrc = 2'b10; c.pcw = 1; end
         "ERROR":            c.ill = 1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic [5:0] op, input bit rdy, input ctl_t exp, input string ph);
      @(negedge clk);
      opcode = op;
      mem_ready = rdy;
      #1;
      checkOutput({"ctl_", ph}, 32'(observed()), 32'(exp));
      checkOutput("count", instr_count, cnt);
      checkOutput("count4", {28'b0, instr_count_s}, cnt % 16);
   endtask

   // Runs one instruction; illegal opcodes sit in the trap for errCycles cycles.
   task automatic applyStimulus(input logic [5:0] op, input int errCycles);
      string phases[$];
      bit    legal = 1;
      int    waits;
      phases = '{"FETCH", "DECODE"};
      case (op)
         6'b100011: begin phases.push_back("MEMADR"); phases.push_back("MEMRD"); phases.push_back("MEMWB"); end
         6'b101011: begin phases.push_back("MEMADR"); phases.push_back("MEMWR"); end
         6'b000000: begin phases.push_back("EXECUTE"); phases.push_back("ALUWB"); end
         6'b000100: phases.push_back("BEQ");
         6'b001000: begin phases.push_back("ADDIEX"); phases.push_back("ADDIWB"); end
         6'b000010: phases.push_back("JUMP");
`ifdef MC_BNE_EN
         6'b000101: phases.push_back("BNE");
`endif
         default:   begin phases.push_back("ERROR"); legal = 0; end
      endcase
      foreach (phases[i]) begin
         if (phases[i] == "FETCH" || phases[i] == "MEMRD" || phases[i] == "MEMWR") begin
            waits = $urandom_range(0, 3);
            repeat (waits) step(op, 1'b0, phaseWord(phases[i], 1'b0), phases[i]);
            step(op, 1'b1, phaseWord(phases[i], 1'b1), phases[i]);
         end else if (phases[i] == "ERROR") begin
            repeat (errCycles) step(op, 1'($urandom_range(0, 1)), phaseWord("ERROR", 1'b0), "ERROR");
         end else begin
            step(op, 1'($urandom_range(0, 1)), phaseWord(phases[i], 1'b0), phases[i]);
         end
      end
      if (legal) cnt++;
   endtask

   task automatic resetPulse();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_ctl", 32'(observed()), 32'h0);
      checkOutput("reset_count", instr_count, 32'h0);
      checkOutput("reset_count4", {28'b0, instr_count_s}, 32'h0);
      cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("idle_ctl", 32'(observed()), 32'h0);
   endtask

   logic [5:0] ops[$] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010
`ifdef MC_BNE_EN
                          , 6'b000101
`endif
                         };

   initial begin
      opcode = 6'b0;
      mem_ready = 1'b0;
      #1 resetPulse();
      repeat (24) applyStimulus(ops[$urandom_range(0, ops.size() - 1)], 0);

      // Store stalled in MEMWR when reset hits: strobes must drop immediately.
      step(6'b101011, 1'b1, phaseWord("FETCH", 1'b1), "FETCH");
      step(6'b101011, 1'b0, phaseWord("DECODE", 1'b0), "DECODE");
      step(6'b101011, 1'b0, phaseWord("MEMADR", 1'b0), "MEMADR");
      step(6'b101011, 1'b0, phaseWord("MEMWR", 1'b0), "MEMWR");
      resetPulse();

      repeat (3) applyStimulus(ops[$urandom_range(0, ops.size() - 1)], 0);
      applyStimulus(6'b111111, 20);
      resetPulse();
`ifndef MC_BNE_EN
      applyStimulus(6'b000101, 5);
      resetPulse();
`endif
      applyStimulus(6'b000000, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
